chacha_serialiser: RTL
======================

# chacha_serialiser

Parallel-to-byte serialiser for ChaCha20 keystream blocks. It accepts a complete 16-word (512-bit) state matrix in one handshake, holds up to two matrices in a ping-pong buffer, and emits them as a continuous stream of 64 bytes per matrix under valid/ready flow control. It is the transmit end of the byte stream that the downstream concatenation buffer collects back into matrices.

## Interface
- DATA_SIZE, 8, width of one output symbol in bits; only 8 is supported.
- NUM_WORDS, 16, 32-bit words per matrix; bytes per matrix = 4*NUM_WORDS = 64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- state_in  in  32 x [0:NUM_WORDS-1]  matrix words; word 0 is serialised first.
- state_valid  in  1  producer offers state_in.
- state_ready  out  1  a free buffer slot exists.
- byte_out  out  DATA_SIZE  current output byte; forced to 0 when byte_valid is low.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  consumer accepts byte_out.
- byte_last  out  1  byte_out is byte 63 of its matrix; gated by byte_valid.
- occupancy  out  2  number of matrices held (0..2).

## Operation
- Storage consists of two 512-bit slots: slot[0] and slot[1]. Pointers wr_slot and rd_slot are 1 bit each. occupancy is 2 bits. byte_idx is a 6-bit counter.
- Load: when state_valid && state_ready is high at a clock edge, state_in is written to slot[wr_slot], wr_slot toggles, and occupancy increments.
- state_ready = !rst && (occupancy != 2). It depends only on registered state. There is no combinational path from byte_ready.
- byte_valid = (occupancy != 0).
- byte_out is selected combinationally from slot[rd_slot] at byte_idx.
- Default byte order is little-endian within each word: byte k = word[k>>2][8*(k&3)+7 : 8*(k&3)].
- Byte transfer: when byte_valid && byte_ready is high at a clock edge, byte_idx increments.
- At the transfer of byte 63: byte_idx wraps to 0, rd_slot toggles, and occupancy decrements. The next matrix, if held, appears in the following cycle with no gap.
- Load and release in the same edge: occupancy is unchanged, and both pointers move.
- state_valid while occupancy == 2: ignored. The producer must hold state_in and state_valid until acceptance. A release in that same cycle does not admit the load; the load is accepted on the next edge.
- byte_ready while byte_valid is low: no effect.
- Under backpressure (byte_ready low), byte_out, byte_last and byte_idx stay stable.
- Slot contents are not reset. Outputs are gated, so stale data is never visible.

## Timing
- Reset, asynchronous and effective immediately: occupancy=0, byte_idx=0, wr_slot=rd_slot=0.
  - Outputs: byte_valid=0, byte_out=0, byte_last=0, state_ready=0 while rst is high.
- state_ready=1 in the first cycle after rst deasserts.
- Load-to-first-byte latency is one edge: if a load is accepted at edge N into an empty block, byte_valid is high after edge N.
- Throughput: 1 byte per cycle sustained. A 64-byte matrix takes 64 cycles with byte_ready held high.
- Back-to-back matrices are seamless when the second load is accepted before byte 63 of the first transfers.
- A reset mid-matrix discards all held matrices. The next accepted load restarts at byte 0 of slot[0].

## Configuration
- SERIALISER_BIG_ENDIAN_EN, if defined: byte order within each word is big-endian, byte k = word[k>>2][31-8*(k&3) : 24-8*(k&3)]. Word order is unchanged.
- Undefined (default): little-endian order, as specified for ChaCha20 keystream serialisation.

## Test plan
- Incrementing matrix: after reset, load a matrix with word i = 0x03020100 + 0x04040404*i and hold byte_ready high.
  - Response: bytes 0x00..0x3F appear on 64 consecutive cycles, byte_last is high only on 0x3F, then byte_valid=0 and occupancy=0.
- Two loads back-to-back: the second matrix is word i = 0x83828180 + 0x04040404*i.
  - Response: occupancy reaches 2 and state_ready goes 0. A third state_valid is held off until the edge after byte 0x3F of the first matrix. Byte 0x80 follows 0x3F with no idle cycle.
- Backpressure: drop byte_ready for 5 cycles while byte_out=0x0A.
  - Response: byte_out stays 0x0A, byte_valid stays 1, and the stream resumes with 0x0B.
- Simultaneous load and release: at occupancy 1, accept a load on the same edge that byte 63 transfers.
  - Response: occupancy stays 1, and the new matrix's byte 0 appears in the next cycle.
- Async reset mid-stream: assert rst between edges at byte_idx 30.
  - Response: byte_valid=0 and byte_out=0 immediately. After release, a new load restarts at byte 0x00.
- With SERIALISER_BIG_ENDIAN_EN defined, load the incrementing matrix.
  - Response: the first four bytes are 0x03, 0x02, 0x01, 0x00, and byte_last is on 0x3C.

Source files
------------

// File: rtl/chacha_serialiser.sv
// -----------------------------------------------------------------------------
// chacha_serialiser
//
// Purpose: parallel-to-byte serialiser for ChaCha20 keystream blocks. A full
// 16-word state matrix is accepted in one valid/ready handshake into one of two
// ping-pong slots. Held matrices are then streamed out as 64 bytes each under
// valid/ready flow control, one byte per cycle and with no gap between
// matrices.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   state_in     in   NUM_WORDS x 32-bit matrix words; word 0 is sent first
//   state_valid  in   producer offers state_in
//   state_ready  out  a free slot exists (registered state only, no path
//                     from byte_ready)
//   byte_out     out  current byte; 0 when byte_valid is low
//   byte_valid   out  at least one matrix is held
//   byte_ready   in   consumer accepts byte_out
//   byte_last    out  byte_out is the final byte of its matrix
//   occupancy    out  number of matrices held (0..2)
//
// Configuration macro:
//   SERIALISER_BIG_ENDIAN_EN  when defined, bytes within each word are sent
//                             most significant first. The default is
//                             little-endian, the ChaCha20 keystream order.
// -----------------------------------------------------------------------------
module chacha_serialiser #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          state_in [0:NUM_WORDS-1],
  input  logic                 state_valid,
  output logic                 state_ready,
  output logic [DATA_SIZE-1:0] byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic [1:0]           occupancy
);

  localparam int unsigned NUM_BYTES = 4 * NUM_WORDS;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES);
  localparam int unsigned WIDX_W    = IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // Ping-pong storage; contents are never reset because every output is gated.
  logic [31:0] slot_q [0:1][0:NUM_WORDS-1];

  logic [1:0]       occ_q, occ_d;
  logic             wr_slot_q, wr_slot_d;
  logic             rd_slot_q, rd_slot_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;

  logic             load_c;
  logic             xfer_c;
  logic             release_c;
  logic [31:0]      word_c;
  logic [1:0]       lane_c;
  logic [7:0]       sel_c;

  // Handshake qualifiers; state_ready is derived from registered occupancy only.
  always_comb begin
    state_ready = !rst && (occ_q != 2'd2);
    byte_valid  = (occ_q != 2'd0);
    load_c      = state_valid && state_ready;
    xfer_c      = byte_valid && byte_ready;
    release_c   = xfer_c && (byte_idx_q == LAST_IDX);
  end

  // Next-state for pointers, byte counter and occupancy.
  always_comb begin
    occ_d      = occ_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    byte_idx_d = byte_idx_q;

    if (load_c) begin
      wr_slot_d = ~wr_slot_q;
    end

    if (xfer_c) begin
      // Counter spans exactly one matrix, so byte 63 wraps to 0 naturally.
      byte_idx_d = IDX_W'(byte_idx_q + IDX_W'(1));
    end

    if (release_c) begin
      rd_slot_d = ~rd_slot_q;
    end

    // A load and a release on the same edge cancel out.
    unique case ({load_c, release_c})
      2'b10:   occ_d = 2'(occ_q + 2'd1);
      2'b01:   occ_d = 2'(occ_q - 2'd1);
      default: occ_d = occ_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      occ_q      <= occ_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Matrix capture into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        slot_q[wr_slot_q][w] <= state_in[w];
      end
    end
  end

  // Byte select from the read slot at the current byte index.
  always_comb begin
    word_c = slot_q[rd_slot_q][byte_idx_q[IDX_W-1:2]];
    lane_c = byte_idx_q[1:0];
    sel_c  = 8'h00;
`ifdef SERIALISER_BIG_ENDIAN_EN
    unique case (lane_c)
      2'd0: sel_c = word_c[31:24];
      2'd1: sel_c = word_c[23:16];
      2'd2: sel_c = word_c[15:8];
      2'd3: sel_c = word_c[7:0];
      default: sel_c = 8'h00;
    endcase
`else
    unique case (lane_c)
      2'd0: sel_c = word_c[7:0];
      2'd1: sel_c = word_c[15:8];
      2'd2: sel_c = word_c[23:16];
      2'd3: sel_c = word_c[31:24];
      default: sel_c = 8'h00;
    endcase
`endif
  end

  // Gated outputs so stale slot contents never reach the consumer.
  always_comb begin
    byte_out  = byte_valid ? DATA_SIZE'(sel_c) : '0;
    byte_last = byte_valid && (byte_idx_q == LAST_IDX);
    occupancy = occ_q;
  end

  // Only the full word index width is meaningful for addressing.
  logic unused_widx_c;
  assign unused_widx_c = (WIDX_W == 0);

endmodule
